alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_arbiter_rr.sv | 33 +++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, ALU opcode set,
// ALU pipeline latencies and the helper that maps a latency onto the FSM state
// in which that latency's value is captured.
package alu_pkg;

  // Post-grant states are encoded consecutively so that a latency maps
  // directly onto a state
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RES  = 3'd2,
    ST_WAIT_ZERO = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_MUL    = 5'b00010,
    OP_AND    = 5'b00011,
    OP_OR     = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_NOT    = 5'b00110,
    OP_SHL    = 5'b00111,
    OP_SHR    = 5'b01000,
    OP_PARITY = 5'b11111
  } alu_op_t;

  // Edges from the grant edge until the ALU result / zero flag are valid
  localparam int unsigned RES_LAT  = 2;
  localparam int unsigned ZERO_LAT = 3;

  // The value with latency 'lat' is sampled on the edge that leaves the state
  // reached lat-1 edges after ISSUE was entered
  function automatic state_t cap_state(input int unsigned lat);
    return state_t'(3'(int'(ST_ISSUE) + lat - 1));
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant selection: searches from last_grant+1 upward, wrapping
// to requester 0, and returns a one-hot grant (all zero when nothing is
// requested).
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Two passes: requesters above last_grant first, then the wrapped range
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) > last_grant)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) <= last_grant)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Multi-requester front end for a shared registered ALU. One transaction is
// in flight at a time: grant, issue, wait for the result, wait one more cycle
// for the lagging zero flag, then hold the response until accepted.
// Optional build macro ALU_ARB_PERF_EN adds per-requester saturating grant
// counters on output grant_count.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [5*NREQ-1:0]   req_opcode,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [4:0]          alu_opcode,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic [15:0]         alu_result,
  input  logic                alu_carry,
  input  logic                alu_zero,
  input  logic                alu_overflow,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_overflow
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [16*NREQ-1:0]  grant_count
`endif
);

  localparam state_t RES_CAP_ST  = cap_state(RES_LAT);
  localparam state_t ZERO_CAP_ST = cap_state(ZERO_LAT);

  state_t          state, state_next;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  last_grant;
  logic            grant_fire;

  logic [4:0]      op_q;
  logic [7:0]      a_q, b_q;
  logic [IDW-1:0]  id_q;
  logic [15:0]     res_q;
  logic            carry_q, zero_q, ovf_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // One-hot grant to requester index
  always_comb begin
    grant_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  assign grant_fire = (state == ST_IDLE) && (|grant);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: fixed walk through the ALU pipeline, response waits for accept
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (|grant)    state_next = ST_ISSUE;
      ST_ISSUE:                    state_next = ST_WAIT_RES;
      ST_WAIT_RES:                 state_next = ST_WAIT_ZERO;
      ST_WAIT_ZERO:                state_next = ST_RESP;
      ST_RESP:      if (rsp_ready) state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs: accept only while idle and out of reset
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (state == ST_IDLE && !reset) req_ready = grant;
    if (state == ST_RESP)           rsp_valid = 1'b1;
  end

  // Command latch on grant, result/flag capture at their ALU latencies
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (grant_fire) begin
        last_grant <= grant_id;
        id_q       <= grant_id;
        op_q       <= req_opcode[5*grant_id +: 5];
        a_q        <= req_a[8*grant_id +: 8];
        b_q        <= req_b[8*grant_id +: 8];
      end
      if (state == RES_CAP_ST) begin
        res_q   <= alu_result;
        carry_q <= alu_carry;
        ovf_q   <= alu_overflow;
      end
      if (state == ZERO_CAP_ST) begin
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_opcode   = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp_id       = id_q;
  assign rsp_result   = res_q;
  assign rsp_carry    = carry_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] cnt_q [NREQ];

  // Per-requester grant counters, saturating at all ones
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (grant_fire) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Pack counters, requester i in bits [16i+15:16i]
  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < NREQ; i++) grant_count[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU whose zero flag
// lags its result by one cycle. Build with ALU_ARB_PERF_EN to also exercise
// grant_count.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [5*NREQ-1:0]   req_opcode = '0;
  logic [8*NREQ-1:0]   req_a = '0;
  logic [8*NREQ-1:0]   req_b = '0;
  logic [4:0]          alu_opcode;
  logic [7:0]          alu_a, alu_b;
  logic [15:0]         alu_result = '0;
  logic                alu_carry = 1'b0;
  logic                alu_zero = 1'b0;
  logic                alu_overflow = 1'b0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_result;
  logic                rsp_carry, rsp_zero, rsp_overflow;
`ifdef ALU_ARB_PERF_EN
  logic [16*NREQ-1:0]  grant_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_count  (grant_count)
`endif
  );

  // Environment ALU: registered result, zero flag one cycle behind
  logic [15:0] n_res;
  logic        n_c, n_o;
  logic [8:0]  sum9;
  always_comb begin
    sum9  = {1'b0, alu_a} + {1'b0, alu_b};
    n_res = '0;
    n_c   = 1'b0;
    n_o   = 1'b0;
    case (alu_op_t'(alu_opcode))
      OP_ADD: begin
        n_res = {7'b0, sum9};
        n_c   = sum9[8];
        n_o   = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      OP_MUL:  n_res = alu_a * alu_b;
      OP_XOR:  n_res = {8'h00, alu_a ^ alu_b};
      OP_NOT:  n_res = ~{8'h00, alu_a};
      default: n_res = '0;
    endcase
  end

  always @(posedge clk) begin
    alu_result   <= n_res;
    alu_carry    <= n_c;
    alu_overflow <= n_o;
    alu_zero     <= (alu_result == 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[5*id +: 5] = op;
    req_a[8*id +: 8]      = a;
    req_b[8*id +: 8]      = b;
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
    #1;
    for (int k = 0; k < 20 && req_ready == '0; k++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_grant"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 12);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  // One transaction from the current negedge: request, grant, response, accept
  task automatic txn(input string tag, input logic [NREQ-1:0] vmask,
                     input logic [NREQ-1:0] exp_grant, input logic [IDW-1:0] exp_id,
                     input logic [15:0] exp_res, input logic exp_c, input logic exp_z,
                     input logic exp_o, input int hold, input bit keep_valid);
    rsp_ready = (hold == 0);
    req_valid = vmask;
    wait_grant(tag, exp_grant);
    @(posedge clk); #1;
    if (!keep_valid) req_valid = '0;
    wait_rsp(tag);
    chk({tag, "_id"},     32'(rsp_id),       32'(exp_id));
    chk({tag, "_result"}, 32'(rsp_result),   32'(exp_res));
    chk({tag, "_carry"},  32'(rsp_carry),    32'(exp_c));
    chk({tag, "_zero"},   32'(rsp_zero),     32'(exp_z));
    chk({tag, "_ovf"},    32'(rsp_overflow), 32'(exp_o));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_valid"},  32'(rsp_valid),  32'd1);
      chk({tag, "_hold_result"}, 32'(rsp_result), 32'(exp_res));
      chk({tag, "_hold_zero"},   32'(rsp_zero),   32'(exp_z));
      chk({tag, "_hold_ready"},  32'(req_ready),  32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int k;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_rsp_id",     32'(rsp_id),     32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_flags",  32'({rsp_carry, rsp_zero, rsp_overflow}), 32'd0);
    chk("rst_alu_ops",    32'({alu_opcode, alu_a, alu_b}), 32'd0);

    // ADD 5+3 from requester 0
    set_req(0, OP_ADD, 8'h05, 8'h03);
    txn("add", 2'b01, 2'b01, 2'd0, 16'h0008, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Signed overflow passes through: 7F+01
    set_req(0, OP_ADD, 8'h7F, 8'h01);
    txn("ovf", 2'b01, 2'b01, 2'd0, 16'h0080, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Carry out: FF+01 on requester 1
    set_req(1, OP_ADD, 8'hFF, 8'h01);
    txn("carry", 2'b10, 2'b10, 2'd1, 16'h0100, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // XOR to zero with backpressure for 10 cycles
    set_req(1, OP_XOR, 8'h5A, 8'h5A);
    txn("xor", 2'b10, 2'b10, 2'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 10, 1'b0);

    // A request raised and dropped while busy is never granted
    rsp_ready = 1'b1;
    set_req(0, OP_ADD, 8'h01, 8'h01);
    req_valid = 2'b01;
    wait_grant("drop", 2'b01);
    @(posedge clk); #1;
    set_req(1, OP_ADD, 8'h02, 8'h02);
    req_valid = 2'b10;
    chk("drop_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    req_valid = '0;
    k = 0;
    while (!rsp_valid && k < 12) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drop_result", 32'(rsp_result), 32'h0002);
    @(posedge clk); #1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (req_ready != '0 || rsp_valid) seen++;
      @(negedge clk); #1;
    end
    chk("drop_no_grant", 32'(seen), 32'd0);

    // Reset during WAIT_RES of a MUL abandons it
    set_req(0, OP_MUL, 8'h10, 8'h10);
    req_valid = 2'b01;
    wait_grant("mid", 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, OP_NOT, 8'hFF, 8'h00);
    set_req(1, OP_NOT, 8'hFF, 8'h00);
    req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("mid_rsp_result", 32'(rsp_result), 32'd0);
    chk("mid_alu_ops",    32'({alu_opcode, alu_a, alu_b}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Both requesters continuously valid: 0,1,0,1
    txn("alt0", 2'b11, 2'b01, 2'd0, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    txn("alt1", 2'b11, 2'b10, 2'd1, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    txn("alt2", 2'b11, 2'b01, 2'd0, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    txn("alt3", 2'b11, 2'b10, 2'd1, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b0);

`ifdef ALU_ARB_PERF_EN
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("perf_reset", 32'(grant_count), 32'd0);
    set_req(0, OP_ADD, 8'h01, 8'h02);
    set_req(1, OP_ADD, 8'h03, 8'h04);
    txn("p0", 2'b01, 2'b01, 2'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    txn("p1", 2'b10, 2'b10, 2'd1, 16'h0007, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    txn("p2", 2'b01, 2'b01, 2'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    txn("p3", 2'b10, 2'b10, 2'd1, 16'h0007, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    txn("p4", 2'b01, 2'b01, 2'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("perf_count", 32'(grant_count), 32'h0002_0003);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
